// File: rtl/fp_pkg.sv
// Shared single-precision FP definitions: field widths, FSM encodings and field extractors.
package fp_pkg;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned BIAS  = 127;
    localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;
    localparam int unsigned Q_W   = MAN_W + 2;
    localparam int unsigned E_W   = EXP_W + 2;

    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_NORM = 2'd3;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

    function automatic logic fp_sign(input logic [FP_W-1:0] x);
        return x[FP_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
        return x[FP_W-2 -: EXP_W];
    endfunction

    function automatic logic [MAN_W-1:0] fp_frac(input logic [FP_W-1:0] x);
        return x[MAN_W-1:0];
    endfunction
endpackage

// File: rtl/mant_div_core.sv
// Radix-2 restoring mantissa divider: one quotient bit per step, Q_W steps per operation.
module mant_div_core
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [MAN_W:0]   ma,
    input  logic [MAN_W:0]   mb,
    output logic [Q_W-1:0]   q,
    output logic             last_c
);
    localparam int unsigned CNT_W = $clog2(Q_W);

    logic [Q_W-1:0]   rem_q, rem_d, rem_sub;
    logic [Q_W-1:0]   q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ge;

    always_comb begin
        ge      = rem_q >= Q_W'(mb);
        rem_sub = ge ? (rem_q - Q_W'(mb)) : rem_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        if (load) begin
            rem_d = Q_W'(ma);
            q_d   = '0;
            cnt_d = '0;
        end else if (step) begin
            q_d   = {q_q[Q_W-2:0], ge};
            // remainder stays below 2*mb, so the shift never loses a set bit
            rem_d = rem_sub << 1;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q      = q_q;
    assign last_c = step && (cnt_q == CNT_W'(Q_W - 1));
endmodule

// File: rtl/fp_divider.sv
// Sequential single-precision divider: control FSM, special-case decode, exponent math and normaliser.
module fp_divider
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    output logic [FP_W-1:0] out,
    output logic            busy,
    output logic            done,
    output logic            of,
    output logic            uf,
    output logic            dz
);
    logic [1:0]      state_q, state_d;
    logic [FP_W-1:0] a_q, a_d, b_q, b_d;
    logic [FP_W-1:0] out_q, out_d;
    logic            spec_pend_q, spec_pend_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            of_q, of_d, uf_q, uf_d, dz_q, dz_d;

    logic            core_load, core_step, core_last_c;
    logic [Q_W-1:0]  div_q;

    logic            sign_c, special_c, ea_zero_c, eb_zero_c, any_max_c;
    logic [E_W-1:0]  e_c, exp_n_c;
    logic [MAN_W-1:0] frac_c;
    logic            n_of_c, n_uf_c;
    fp32_t           inf_c, zero_c, norm_c;

    mant_div_core u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (core_load),
        .step   (core_step),
        .ma     ({1'b1, fp_frac(a_q)}),
        .mb     ({1'b1, fp_frac(b_q)}),
        .q      (div_q),
        .last_c (core_last_c)
    );

    // Operand decode and normalisation, all from the latched operands.
    always_comb begin
        sign_c    = fp_sign(a_q) ^ fp_sign(b_q);
        ea_zero_c = fp_exp(a_q) == '0;
        eb_zero_c = fp_exp(b_q) == '0;
        any_max_c = (fp_exp(a_q) == EXP_MAX) || (fp_exp(b_q) == EXP_MAX);
        special_c = ea_zero_c || eb_zero_c || any_max_c;
        e_c       = E_W'(fp_exp(a_q)) - E_W'(fp_exp(b_q)) + E_W'(BIAS);
        if (div_q[Q_W-1]) begin
            frac_c  = div_q[Q_W-2:1];
            exp_n_c = e_c;
        end else begin
            frac_c  = div_q[MAN_W-1:0];
            exp_n_c = e_c - E_W'(1);
        end
        // exponent is two's complement: sign bit set means negative
        n_of_c = !exp_n_c[E_W-1] && (exp_n_c >= E_W'(EXP_MAX));
        n_uf_c = exp_n_c[E_W-1] || (exp_n_c == '0);
        inf_c  = '{sign: sign_c, exp: EXP_MAX, frac: '0};
        zero_c = '{sign: sign_c, exp: '0, frac: '0};
        norm_c = '{sign: sign_c, exp: exp_n_c[EXP_W-1:0], frac: frac_c};
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        out_d       = out_q;
        spec_pend_d = spec_pend_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        of_d        = of_q;
        uf_d        = uf_q;
        dz_d        = dz_q;
        core_load   = 1'b0;
        core_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    of_d    = 1'b0;
                    uf_d    = 1'b0;
                    dz_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!special_c) begin
                    core_load = 1'b1;
                    state_d   = ST_DIV;
                end else if (!spec_pend_q) begin
                    spec_pend_d = 1'b1;
                end else begin
                    // divisor zero outranks dividend zero, which outranks inf/NaN operands
                    if (eb_zero_c) begin
                        dz_d  = 1'b1;
                        out_d = inf_c;
                    end else if (ea_zero_c) begin
                        out_d = zero_c;
                    end else begin
                        of_d  = 1'b1;
                        out_d = inf_c;
                    end
                    spec_pend_d = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_DIV: begin
                core_step = 1'b1;
                if (core_last_c) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (n_of_c) begin
                    of_d  = 1'b1;
                    out_d = inf_c;
                end else if (n_uf_c) begin
                    uf_d  = 1'b1;
                    out_d = zero_c;
                end else begin
                    out_d = norm_c;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            spec_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            of_q        <= 1'b0;
            uf_q        <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            spec_pend_q <= spec_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            of_q        <= of_d;
            uf_q        <= uf_d;
            dz_q        <= dz_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
    assign of   = of_q;
    assign uf   = uf_q;
    assign dz   = dz_q;
endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed vector table, corner sequences and a randomized model check.
module tb_fp_divider;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] in_a, in_b, out;
    logic        busy, done, of, uf, dz;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    fp_divider dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in_a  (in_a),
        .in_b  (in_b),
        .out   (out),
        .busy  (busy),
        .done  (done),
        .of    (of),
        .uf    (uf),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: quotient as an exact integer division, then IEEE field assembly.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [2:0] fl, output int lat);
        logic        s;
        int          ea, eb, e;
        longint      ma, mb, q;
        logic [22:0] fr;
        s   = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        fl  = 3'b000;
        lat = 2;
        if (eb == 0) begin
            fl = 3'b001; r = {s, 8'hFF, 23'h0};
        end else if (ea == 0) begin
            r = {s, 31'h0};
        end else if (ea == 255 || eb == 255) begin
            fl = 3'b100; r = {s, 8'hFF, 23'h0};
        end else begin
            lat = 27;
            ma  = longint'({1'b1, a[22:0]});
            mb  = longint'({1'b1, b[22:0]});
            q   = (ma * 64'd16777216) / mb;
            e   = ea - eb + 127;
            if (q >= 64'd16777216) begin
                fr = q[23:1];
            end else begin
                fr = q[22:0];
                e  = e - 1;
            end
            if (e >= 255) begin
                fl = 3'b100; r = {s, 8'hFF, 23'h0};
            end else if (e <= 0) begin
                fl = 3'b010; r = {s, 31'h0};
            end else begin
                r = {s, 8'(e), fr};
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in_a  = $urandom;
        in_b  = $urandom;
    endtask

    task automatic wait_done(input logic [31:0] hold, input bit chk_hold, input bit disturb,
                             output int lat, output bit held_ok);
        lat     = 0;
        held_ok = 1'b1;
        while (!done && lat < 60) begin
            if (chk_hold && out !== hold) held_ok = 1'b0;
            if (disturb && lat == 5) begin
                start = 1'b1; in_a = $urandom; in_b = $urandom;
            end
            if (disturb && lat == 6) start = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic [2:0] fl, input int lat_exp, input bit disturb);
        int lat;
        bit held;
        issue(a, b);
        wait_done(32'h0, 1'b0, disturb, lat, held);
        check({name, " out"}, out, r);
        check({name, " flags"}, 32'({of, uf, dz}), 32'(fl));
        check({name, " latency"}, 32'(lat), 32'(lat_exp));
        check({name, " busy_at_done"}, 32'(busy), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check({name, " done_pulse"}, 32'(done), 32'(0));
        check({name, " out_held"}, out, r);
    endtask

    initial begin
        logic [31:0] ra, rb, rr;
        logic [2:0]  rfl;
        int          rlat, lat;
        bit          held, seen;

        vecs[0]  = '{32'h41600000, 32'h40000000, 32'h40E00000, 3'b000, 27};
        vecs[1]  = '{32'hC1200000, 32'h40000000, 32'hC0A00000, 3'b000, 27};
        vecs[2]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 27};
        vecs[3]  = '{32'h40000000, 32'h00000000, 32'h7F800000, 3'b001, 2};
        vecs[4]  = '{32'h00000000, 32'h40000000, 32'h00000000, 3'b000, 2};
        vecs[5]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100, 27};
        vecs[6]  = '{32'h00800000, 32'h4B000000, 32'h00000000, 3'b010, 27};
        vecs[7]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 3'b100, 2};
        vecs[8]  = '{32'h80000000, 32'h00000000, 32'hFF800000, 3'b001, 2};
        vecs[9]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 27};
        vecs[10] = '{32'h00400000, 32'h3F800000, 32'h00000000, 3'b000, 2};
        vecs[11] = '{32'h00800000, 32'h40000000, 32'h00000000, 3'b010, 27};
        vecs[12] = '{32'h00800000, 32'h3F800000, 32'h00800000, 3'b000, 27};
        vecs[13] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 3'b100, 27};
        vecs[14] = '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 3'b000, 27};

        reset = 1'b1; start = 1'b0; in_a = '0; in_b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset out", out, 32'h0);
        check("reset ctl", 32'({busy, done, of, uf, dz}), 32'h0);

        for (int i = 0; i < 15; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].fl, vecs[i].lat, 1'b0);
        end

        // start pulsed mid-operation with new operands must be ignored
        run_vec("ignore_start", 32'h41600000, 32'h40000000, 32'h40E00000, 3'b000, 27, 1'b1);

        // async reset in the middle of the mantissa loop
        issue(32'h3F800000, 32'h40400000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("busy mid_div", 32'(busy), 32'(1));
        reset = 1'b1;
        #1;
        check("mid_reset out", out, 32'h0);
        check("mid_reset ctl", 32'({busy, done, of, uf, dz}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("mid_reset no_done", 32'(seen), 32'(0));

        // back-to-back: second start in the done cycle
        issue(32'h41600000, 32'h40000000);
        wait_done(32'h0, 1'b0, 1'b0, lat, held);
        check("b2b first", out, 32'h40E00000);
        issue(32'h3F800000, 32'h40400000);
        wait_done(32'h40E00000, 1'b1, 1'b0, lat, held);
        check("b2b hold", 32'(held), 32'(1));
        check("b2b latency", 32'(lat), 32'(27));
        check("b2b second", out, 32'h3EAAAAAA);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                ra[30:23] = 8'($urandom_range(90, 164));
                rb[30:23] = 8'($urandom_range(90, 164));
            end
            ref_div(ra, rb, rr, rfl, rlat);
            run_vec($sformatf("rand%0d", i), ra, rb, rr, rfl, rlat, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
